// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU flag indices, opcodes and result-entry type
package alu_pkg;

    // Bit positions inside the 4-bit flag vector {Cout, Negative, Zero, Overflow}
    localparam int FLAG_COUT = 3;
    localparam int FLAG_NEG  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_OVF  = 0;

    // Widest result the entry type can carry; instances use the low WIDTH bits
    localparam int ALU_Y_W = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_NOT  = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_ADDC = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SUBB = 4'b0111,
        ALU_INC  = 4'b1000,
        ALU_DEC  = 4'b1001,
        ALU_SHL  = 4'b1010,
        ALU_SHR  = 4'b1011,
        ALU_ROL  = 4'b1100,
        ALU_ASR  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic [ALU_Y_W-1:0] y;
        logic [3:0]         flags;
        logic [3:0]         sel;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - circular result FIFO with stall counter; optional sticky flags under ALU_RESULT_STICKY_EN
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_y,
    input  logic [3:0]                 in_flags,
    input  logic [3:0]                 in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_y,
    output logic [3:0]                 out_flags,
    output logic [3:0]                 out_sel,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 stall_cnt
`ifdef ALU_RESULT_STICKY_EN
    ,
    input  logic                       sticky_clr,
    output logic [3:0]                 sticky_flags
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    generate
        if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8) || WIDTH > ALU_Y_W || WIDTH < 1) begin : g_bad_param
            $error("alu_result_fifo: DEPTH must be 2, 4 or 8 and WIDTH within 1..ALU_Y_W");
        end
    endgenerate

    alu_entry_t      mem [DEPTH];
    alu_entry_t      head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   head_idx;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    // Ready depends only on occupancy, so a pop while full never frees the slot in the same cycle
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When empty the read pointer already sits past the last-read slot, so step back one to keep showing it
    always_comb begin
        head_idx = out_valid ? rd_ptr : ptr_dec(rd_ptr);
        head     = mem[head_idx];
    end

    assign out_y     = head.y[WIDTH-1:0];
    assign out_flags = head.flags;
    assign out_sel   = head.sel;

    // Pointer, occupancy and stall bookkeeping; reset discards any coincident push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && !in_ready && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;
        end
    end

    // Storage is never reset; a write during reset is suppressed so the push is truly discarded
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= '{y: ALU_Y_W'(in_y), flags: in_flags, sel: in_sel};
    end

`ifdef ALU_RESULT_STICKY_EN
    // Accumulate flags of accepted pushes; a clear alongside a push restarts from that push's flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_flags <= '0;
        else if (push)
            sticky_flags <= sticky_clr ? in_flags : (sticky_flags | in_flags);
        else if (sticky_clr)
            sticky_flags <= '0;
    end
`endif

endmodule
